pixel_frame_source: RTL
=======================

# pixel_frame_source

Generates the raster pixel stream consumed by the pixel-processing blocks: one 11-bit pixel per clock, a frame strobe on the first pixel of a frame, a line strobe on the first pixel of every later line. Pixels are fetched from a synchronous frame RAM by linear address. It sits at the head of the image pipeline, so the Circle/Hough stages see a correctly framed stream without a camera.

## Interface
- No parameters. Geometry is runtime via Width/Height.
- Clk  in  1  system clock, all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- Start  in  1  request one frame; sampled in IDLE only
- Continuous  in  1  if high when the last pixel is issued, the next frame follows with no gap
- Width  in  8  pixels per line; sampled at frame start
- Height  in  8  lines per frame; sampled at frame start
- RdEn  out  1  RAM read strobe
- RdAddr  out  16  RAM address = y*Width + x
- RdData  in  11  RAM data, valid the cycle after RdEn
- PixelOut  out  11  pixel value
- PixelValid  out  1  high for every emitted pixel
- FrameOut  out  1  high with pixel (0,0) only
- LineOut  out  1  high with pixel (0,y) for y ≥ 1
- Busy  out  1  high from accepted Start until Done
- Done  out  1  one-cycle pulse after last pixel of the final frame

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Start=1 with Width≠0 and Height≠0: latch Width/Height, zero x, y and the address counter, go to RUN.
  - Start=1 with Width=0 or Height=0: no RAM access, no pixels, Done pulses next cycle, stay in IDLE.
- RUN: one RdEn per cycle at RdAddr.
  - x increments each cycle.
  - When x = W-1: x←0, y increments.
  - When x = W-1 and y = H-1:
    - Continuous=1: relatch Width/Height, reset counters, remain in RUN.
    - Otherwise: go to DRAIN.
- Address is a 16-bit incrementing counter, never a multiply. Maximum 255*255-1 = 65024, so there is no wrap.
- First/line flags are computed alongside the address and delayed two stages to align with RdData.
- DRAIN: two cycles, no RdEn. Pipeline empties, then Done pulses and the block returns to IDLE.
- Start while Busy is ignored. Width/Height changes mid-frame are ignored.
- Between frames in Continuous mode, FrameOut marks the new frame with no idle cycle.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame clears the block immediately, with no Done pulse. The frame is abandoned.
- Start is sampled at edge k.
  - After edge k: Busy=1, RdEn=1, RdAddr=0.
  - After edge k+2: PixelOut = RAM[0], PixelValid=1, FrameOut=1.
  - Latency is 2 cycles from address issue to output.
- Output stream is continuous: W*H consecutive PixelValid cycles, no gaps between lines.
- Done is high for exactly one cycle, the cycle after the last PixelValid. Busy falls in the same cycle Done is high.
- Start may be reasserted in the cycle after Done.
- FrameOut and LineOut are never high together, and never high without PixelValid.
- W=1: LineOut on every pixel except the first. H=1: no LineOut.

## Configuration
- PIXEL_TEST_PATTERN_EN
  - Defined: RdEn is tied 0 and RdData is ignored. PixelOut = {3'b000, x ^ y}, using the x,y of that pixel. Timing, strobes, Busy and Done are unchanged, including the 2-cycle latency.
  - Undefined: pixels come from RdData as above.

## Test plan
- W=4, H=3, Start pulse, RAM[a]=a:
  - PixelOut 0..11 on 12 consecutive cycles.
  - FrameOut on pixel 0; LineOut on pixels 4 and 8.
  - Done 1 cycle after pixel 11; Busy 14 cycles total.
- W=255, H=255:
  - Final RdAddr = 65024.
  - 65025 PixelValid cycles.
  - Exactly 254 LineOut pulses.
- W=2, H=2, Continuous=1 for 3 frames, then 0:
  - 12 consecutive pixels.
  - FrameOut at pixel indices 0, 4, 8.
  - A single Done at the end.
- W=0, H=5, Start:
  - No RdEn, no PixelValid.
  - Done pulses 1 cycle after Start; Busy stays 0.
- nReset asserted mid-line of a W=8, H=8 frame:
  - All outputs 0 immediately, no Done.
  - New Start produces a full frame from RdAddr 0.
- With PIXEL_TEST_PATTERN_EN, W=4, H=2:
  - PixelOut sequence 0,1,2,3,1,0,3,2.
  - RdEn stays 0 throughout.

Source files
------------

// File: rtl/pixel_frame_source.sv
// Raster pixel source: walks a W x H frame by linear RAM address and emits one pixel per clock with frame/line strobes.
// Optional build macro PIXEL_TEST_PATTERN_EN replaces RAM data with an x^y test pattern and silences RdEn.
module pixel_frame_source (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Start,
  input  logic        Continuous,
  input  logic [7:0]  Width,
  input  logic [7:0]  Height,
  output logic        RdEn,
  output logic [15:0] RdAddr,
  input  logic [10:0] RdData,
  output logic [10:0] PixelOut,
  output logic        PixelValid,
  output logic        FrameOut,
  output logic        LineOut,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_done_next;

  logic [7:0]  r_width;
  logic [7:0]  r_height;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [15:0] r_addr;
  logic        r_drain_cnt;

  logic        r_v1;
  logic        r_f1;
  logic        r_l1;
  logic [10:0] r_pix;
  logic        r_valid;
  logic        r_frame;
  logic        r_line;
  logic        r_done;

  logic        w_run;
  logic        w_dims_ok;
  logic        w_start_ok;
  logic        w_start_zero;
  logic        w_last_x;
  logic        w_last_pix;
  logic        w_relatch;

  assign w_run        = (r_state == ST_RUN);
  assign w_dims_ok    = (Width != 8'd0) && (Height != 8'd0);
  assign w_start_ok   = Start && w_dims_ok;
  assign w_start_zero = Start && !w_dims_ok;
  assign w_last_x     = (r_x == r_width - 8'd1);
  assign w_last_pix   = w_last_x && (r_y == r_height - 8'd1);
  // A back-to-back frame needs non-degenerate geometry; otherwise finish normally.
  assign w_relatch    = w_last_pix && Continuous && w_dims_ok;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_next = ST_RUN;
        end else if (w_start_zero) begin
          w_done_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_last_pix && !w_relatch) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_width     <= 8'd0;
      r_height    <= 8'd0;
      r_x         <= 8'd0;
      r_y         <= 8'd0;
      r_addr      <= 16'd0;
      r_drain_cnt <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_drain_cnt <= 1'b0;
          if (w_start_ok) begin
            r_width  <= Width;
            r_height <= Height;
            r_x      <= 8'd0;
            r_y      <= 8'd0;
            r_addr   <= 16'd0;
          end
        end
        ST_RUN: begin
          r_drain_cnt <= 1'b0;
          if (w_last_pix) begin
            r_x    <= 8'd0;
            r_y    <= 8'd0;
            r_addr <= 16'd0;
            if (w_relatch) begin
              r_width  <= Width;
              r_height <= Height;
            end
          end else if (w_last_x) begin
            r_x    <= 8'd0;
            r_y    <= r_y + 8'd1;
            r_addr <= r_addr + 16'd1;
          end else begin
            r_x    <= r_x + 8'd1;
            r_addr <= r_addr + 16'd1;
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= ~r_drain_cnt;
        end
        default: r_drain_cnt <= 1'b0;
      endcase
    end
  end

`ifdef PIXEL_TEST_PATTERN_EN
  logic [7:0] r_p1;
`endif

  // Stage 1 lines up with the RAM read; stage 2 registers the pixel with its strobes.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_v1    <= 1'b0;
      r_f1    <= 1'b0;
      r_l1    <= 1'b0;
      r_pix   <= 11'd0;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
      r_line  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PIXEL_TEST_PATTERN_EN
      r_p1    <= 8'd0;
`endif
    end else begin
      r_v1    <= w_run;
      r_f1    <= w_run && (r_x == 8'd0) && (r_y == 8'd0);
      r_l1    <= w_run && (r_x == 8'd0) && (r_y != 8'd0);
      r_valid <= r_v1;
      r_frame <= r_f1;
      r_line  <= r_l1;
      r_done  <= w_done_next;
`ifdef PIXEL_TEST_PATTERN_EN
      r_p1    <= w_run ? (r_x ^ r_y) : 8'd0;
      r_pix   <= r_v1 ? {3'b000, r_p1} : 11'd0;
`else
      r_pix   <= r_v1 ? RdData : 11'd0;
`endif
    end
  end

`ifdef PIXEL_TEST_PATTERN_EN
  assign RdEn = 1'b0;
`else
  assign RdEn = w_run;
`endif
  assign RdAddr     = r_addr;
  assign PixelOut   = r_pix;
  assign PixelValid = r_valid;
  assign FrameOut   = r_frame;
  assign LineOut    = r_line;
  assign Busy       = (r_state != ST_IDLE);
  assign Done       = r_done;

endmodule
